// File: rtl/subservient_arb_defs.sv
// -----------------------------------------------------------------------------
// subservient_arb_defs
//   Shared definitions for the two-master GPIO arbiter:
//   - FSM state encodings (IDLE / GNT0 / GNT1)
//   - default slave-ack timeout, in clock cycles
// No ports; imported by subservient_gpio_arbiter and subservient_arb_timer.
// -----------------------------------------------------------------------------
package subservient_arb_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage : subservient_arb_defs

// File: rtl/subservient_arb_timer.sv
// -----------------------------------------------------------------------------
// subservient_arb_timer
//   Slave-ack watchdog for the GPIO arbiter. Only compiled when the macro
//   SUBSERVIENT_GPIO_ARB_TIMEOUT_EN is defined.
//   The 8-bit count is held at zero while no grant is active, so every grant
//   starts counting from zero. expired_o rises in the TIMEOUT_CYCLES-th
//   cycle of a grant.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-high reset
//   run_i      in   high while the arbiter holds a grant
//   expired_o  out  grant has lasted TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
`ifdef SUBSERVIENT_GPIO_ARB_TIMEOUT_EN
module subservient_arb_timer
    import subservient_arb_defs::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign expired_o = run_i && (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (!run_i) begin
            count_d = 8'd0;
        end else if (!expired_o) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : subservient_arb_timer
`endif

// File: rtl/subservient_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// subservient_gpio_arbiter
//   Arbitrates two single-bit Wishbone-style masters (m0 = CPU, m1 = aux)
//   onto one single-bit GPIO slave. Round-robin on simultaneous requests:
//   the master not served last wins. Write data/enable are registered at
//   grant and held for the whole grant; ack and read data are forwarded
//   combinationally from the slave to the granted master only.
//
//   Optional feature (macro SUBSERVIENT_GPIO_ARB_TIMEOUT_EN): a grant that
//   sees no slave ack for TIMEOUT_CYCLES cycles is acked to its master with
//   read data 0, o_err pulses for one cycle and the arbiter returns to IDLE.
//   Without the macro o_err is tied low and a grant waits for i_s_ack forever.
//
// Parameters
//   TIMEOUT_CYCLES  slave-ack timeout in cycles, legal range 2..255
//
// Ports
//   i_wb_clk            in   clock, all state on rising edge
//   i_wb_rst            in   asynchronous active-high reset
//   i_m0_dat/i_m1_dat   in   write data per master
//   i_m0_we/i_m1_we     in   write enable per master
//   i_m0_stb/i_m1_stb   in   request strobe per master, held until ack
//   o_m0_rdt/o_m1_rdt   out  read data per master (0 unless acked)
//   o_m0_ack/o_m1_ack   out  single-cycle ack per master
//   o_s_dat/o_s_we      out  registered write data/enable to slave
//   o_s_stb             out  slave strobe, high exactly while granted
//   i_s_rdt/i_s_ack     in   slave read data / ack
//   o_err               out  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module subservient_gpio_arbiter
    import subservient_arb_defs::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst,

    input  logic i_m0_dat,
    input  logic i_m0_we,
    input  logic i_m0_stb,
    output logic o_m0_rdt,
    output logic o_m0_ack,

    input  logic i_m1_dat,
    input  logic i_m1_we,
    input  logic i_m1_stb,
    output logic o_m1_rdt,
    output logic o_m1_ack,

    output logic o_s_dat,
    output logic o_s_we,
    output logic o_s_stb,
    input  logic i_s_rdt,
    input  logic i_s_ack,

    output logic o_err
);

    logic [1:0] state_q, state_d;
    logic       ptr_q,   ptr_d;    // master with priority on a tie
    logic       dat_q,   dat_d;
    logic       we_q,    we_d;

    logic       gnt0;
    logic       gnt1;
    logic       in_gnt;
    logic       timeout;
    logic       done;

    assign gnt0   = (state_q == ST_GNT0);
    assign gnt1   = (state_q == ST_GNT1);
    assign in_gnt = gnt0 || gnt1;

`ifdef SUBSERVIENT_GPIO_ARB_TIMEOUT_EN
    logic expired;

    subservient_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (i_wb_clk),
        .rst_i     (i_wb_rst),
        .run_i     (in_gnt),
        .expired_o (expired)
    );

    // A real ack in the expiry cycle wins over the timeout.
    assign timeout = expired && !i_s_ack;
`else
    assign timeout = 1'b0;
`endif

    // i_s_ack outside a grant is ignored because done needs in_gnt.
    assign done = in_gnt && (i_s_ack || timeout);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                // Inline priority pick: m0 wins unless m1 also asks and
                // holds the priority pointer.
                if (i_m0_stb && (!i_m1_stb || !ptr_q)) begin
                    state_d = ST_GNT0;
                    dat_d   = i_m0_dat;
                    we_d    = i_m0_we;
                end else if (i_m1_stb) begin
                    state_d = ST_GNT1;
                    dat_d   = i_m1_dat;
                    we_d    = i_m1_we;
                end
            end
            ST_GNT0: begin
                if (done) begin
                    state_d = ST_IDLE;
                    ptr_d   = 1'b1;
                end
            end
            ST_GNT1: begin
                if (done) begin
                    state_d = ST_IDLE;
                    ptr_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            dat_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
        end
    end

    // Strobe decodes straight from state, so an asynchronous reset drops it
    // in the same cycle and no ack can follow for the aborted transfer.
    assign o_s_stb  = in_gnt;
    assign o_s_dat  = dat_q;
    assign o_s_we   = we_q;

    assign o_m0_ack = gnt0 && (i_s_ack || timeout);
    assign o_m1_ack = gnt1 && (i_s_ack || timeout);

    // Read data only passes with a real slave ack; a timeout returns 0.
    assign o_m0_rdt = gnt0 && i_s_ack && i_s_rdt;
    assign o_m1_rdt = gnt1 && i_s_ack && i_s_rdt;

    assign o_err    = in_gnt && timeout;

endmodule : subservient_gpio_arbiter

// File: tb/tb_subservient_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_subservient_gpio_arbiter
//   Directed bench for subservient_gpio_arbiter with a one-cycle GPIO slave
//   model. The slave can be switched to a manual mode where its ack is
//   driven directly (stuck low or a spurious pulse).
// -----------------------------------------------------------------------------
module tb_subservient_gpio_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic m0_dat = 1'b0, m0_we = 1'b0, m0_stb = 1'b0;
    logic m1_dat = 1'b0, m1_we = 1'b0, m1_stb = 1'b0;
    logic m0_rdt, m0_ack, m1_rdt, m1_ack;
    logic s_dat, s_we, s_stb;
    logic s_ack = 1'b0;
    logic err;

    // Slave model state
    logic gpio      = 1'b0;
    logic slv_auto  = 1'b1;
    logic slv_force = 1'b0;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    subservient_gpio_arbiter #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_m0_dat (m0_dat),
        .i_m0_we  (m0_we),
        .i_m0_stb (m0_stb),
        .o_m0_rdt (m0_rdt),
        .o_m0_ack (m0_ack),
        .i_m1_dat (m1_dat),
        .i_m1_we  (m1_we),
        .i_m1_stb (m1_stb),
        .o_m1_rdt (m1_rdt),
        .o_m1_ack (m1_ack),
        .o_s_dat  (s_dat),
        .o_s_we   (s_we),
        .o_s_stb  (s_stb),
        .i_s_rdt  (gpio),
        .i_s_ack  (s_ack),
        .o_err    (err)
    );

    // One-cycle slave: registers the strobe, acks in the next cycle.
    always @(posedge clk) begin
        if (slv_auto) begin
            if (s_stb && !s_ack) begin
                s_ack <= 1'b1;
                if (s_we) gpio <= s_dat;
            end else begin
                s_ack <= 1'b0;
            end
        end else begin
            s_ack <= slv_force;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int ack_seen;
    int err_seen;

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_s_stb", s_stb, 1'b0);
        check("rst_s_dat", s_dat, 1'b0);
        check("rst_s_we",  s_we,  1'b0);
        check("rst_err",   err,   1'b0);
        check("rst_m0_ack", m0_ack, 1'b0);
        check("rst_m1_ack", m1_ack, 1'b0);
        tick();
        rst = 1'b0;

        // ---------------- m0 write 1 alone ----------------
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b1;
        tick();
        check("w0_c1_s_stb", s_stb, 1'b1);
        check("w0_c1_s_dat", s_dat, 1'b1);
        check("w0_c1_s_we",  s_we,  1'b1);
        check("w0_c1_m0_ack", m0_ack, 1'b0);
        tick();
        check("w0_c2_m0_ack", m0_ack, 1'b1);
        check("w0_c2_m1_ack", m1_ack, 1'b0);
        check("w0_c2_gpio",   gpio,   1'b1);
        m0_stb = 1'b0;
        tick();
        check("w0_c3_s_stb", s_stb, 1'b0);
        check("w0_c3_m0_ack", m0_ack, 1'b0);

        // ---------------- spurious slave ack in IDLE ----------------
        slv_auto = 1'b0; slv_force = 1'b1;
        tick();
        check("spur_m0_ack", m0_ack, 1'b0);
        check("spur_m1_ack", m1_ack, 1'b0);
        check("spur_m0_rdt", m0_rdt, 1'b0);
        check("spur_m1_rdt", m1_rdt, 1'b0);
        slv_force = 1'b0;
        tick();
        check("spur_s_stb", s_stb, 1'b0);
        slv_auto = 1'b1;

        // ---------------- simultaneous pair after reset ----------------
        do_reset();
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b0;
        m1_stb = 1'b1; m1_we = 1'b1; m1_dat = 1'b1;
        tick();
        check("p1_c1_s_stb", s_stb, 1'b1);
        check("p1_c1_s_dat_m0", s_dat, 1'b0);
        tick();
        check("p1_c2_m0_ack", m0_ack, 1'b1);
        check("p1_c2_m1_ack", m1_ack, 1'b0);
        check("p1_c2_gpio",   gpio,   1'b0);
        m0_stb = 1'b0;
        tick();
        check("p1_gap_s_stb", s_stb, 1'b0);
        tick();
        check("p1_c4_s_stb", s_stb, 1'b1);
        check("p1_c4_s_dat_m1", s_dat, 1'b1);
        tick();
        check("p1_c5_m1_ack", m1_ack, 1'b1);
        check("p1_c5_m0_ack", m0_ack, 1'b0);
        check("p1_c5_gpio",   gpio,   1'b1);
        m1_stb = 1'b0;
        tick();
        check("p1_end_s_stb", s_stb, 1'b0);

        // ---------------- pair after m1 served last: m0 first, m1 reads ----
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b1;
        m1_stb = 1'b1; m1_we = 1'b0; m1_dat = 1'b0;
        tick();
        check("p2_c1_s_we_m0", s_we, 1'b1);
        tick();
        check("p2_c2_m0_ack", m0_ack, 1'b1);
        m0_stb = 1'b0;
        tick();
        check("p2_gap_s_stb", s_stb, 1'b0);
        tick();
        check("p2_rd_c1_s_we", s_we, 1'b0);
        check("p2_rd_c1_m1_ack", m1_ack, 1'b0);
        check("p2_rd_c1_m1_rdt", m1_rdt, 1'b0);
        tick();
        check("p2_rd_m1_ack", m1_ack, 1'b1);
        check("p2_rd_m1_rdt", m1_rdt, 1'b1);
        check("p2_rd_m0_ack", m0_ack, 1'b0);
        m1_stb = 1'b0;
        tick();

        // ---------------- m0 alone, then pair: m1 must win ----------------
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b1;
        tick();
        tick();
        check("s3_m0_ack", m0_ack, 1'b1);
        m0_stb = 1'b0;
        tick();
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b0;
        m1_stb = 1'b1; m1_we = 1'b1; m1_dat = 1'b1;
        tick();
        check("p3_c1_s_dat_m1", s_dat, 1'b1);
        tick();
        check("p3_c2_m1_ack", m1_ack, 1'b1);
        check("p3_c2_m0_ack", m0_ack, 1'b0);
        m1_stb = 1'b0;
        tick();
        tick();
        check("p3_c4_s_dat_m0", s_dat, 1'b0);
        tick();
        check("p3_c5_m0_ack", m0_ack, 1'b1);
        m0_stb = 1'b0;
        tick();

        // ---------------- m0 drops strobe mid-grant ----------------
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b0;
        tick();
        check("drop_c1_s_stb", s_stb, 1'b1);
        m0_stb = 1'b0;
        tick();
        check("drop_c2_m0_ack", m0_ack, 1'b1);
        check("drop_c2_gpio",   gpio,   1'b0);
        tick();
        check("drop_c3_s_stb", s_stb, 1'b0);

        // ---------------- reset in GNT0 cycle 1 (pointer currently m1) ----
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b1;
        tick();
        check("ar_c1_s_stb", s_stb, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("ar_s_stb_async", s_stb, 1'b0);
        check("ar_m0_ack",      m0_ack, 1'b0);
        check("ar_s_dat",       s_dat,  1'b0);
        tick();
        check("ar_m0_ack_next", m0_ack, 1'b0);
        check("ar_gpio_unwritten", gpio, 1'b0);
        rst = 1'b0;
        m0_stb = 1'b1; m0_we = 1'b1; m0_dat = 1'b0;
        m1_stb = 1'b1; m1_we = 1'b1; m1_dat = 1'b1;
        tick();
        check("ar_ptr0_s_dat_m0", s_dat, 1'b0);
        tick();
        check("ar_ptr0_m0_ack", m0_ack, 1'b1);
        m0_stb = 1'b0;
        tick();
        tick();
        tick();
        check("ar_m1_ack", m1_ack, 1'b1);
        m1_stb = 1'b0;
        tick();

        // ---------------- slave ack stuck low ----------------
        // gpio is 1 here, so an ungated rdt would show up as 1.
        slv_auto = 1'b0; slv_force = 1'b0;
        m0_stb = 1'b1; m0_we = 1'b0; m0_dat = 1'b0;
`ifdef SUBSERVIENT_GPIO_ARB_TIMEOUT_EN
        for (int c = 1; c < TMO; c++) begin
            tick();
            check($sformatf("tmo_c%0d_m0_ack", c), m0_ack, 1'b0);
            check($sformatf("tmo_c%0d_err", c), err, 1'b0);
        end
        tick();
        check("tmo_m0_ack", m0_ack, 1'b1);
        check("tmo_err",    err,    1'b1);
        check("tmo_m0_rdt", m0_rdt, 1'b0);
        m0_stb = 1'b0;
        tick();
        check("tmo_after_s_stb", s_stb, 1'b0);
        check("tmo_after_err",   err,   1'b0);
`else
        ack_seen = 0;
        err_seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (m0_ack || m1_ack) ack_seen++;
            if (err) err_seen++;
        end
        check("stuck_no_ack", ack_seen == 0, 1'b1);
        check("stuck_no_err", err_seen == 0, 1'b1);
        check("stuck_s_stb",  s_stb, 1'b1);
        m0_stb = 1'b0;
        do_reset();
        check("stuck_rst_s_stb", s_stb, 1'b0);
`endif
        slv_auto = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule : tb_subservient_gpio_arbiter
